cram_loader: RTL and testbench

- Configuration sequencer for the fabric's serial CRAM chain, i.e. the daisy-chained config_data_in/config_data_out path through every LE, LEI, CB and SB of each tile.
- Accepts the bitstream as parallel words over a valid/ready handshake, serializes them LSB-first into the chain head with config_en, and counts exactly CHAIN_BITS shifts.
- Holds the user fabric disabled (le_en low) until configuration completes, then releases it.
- Sits between the host/bitstream source and the tile array top level.

---
 rtl/cram_loader_if.sv | 16 +
 rtl/cram_loader.sv | 158 +++++++++++++++
 tb/tb_cram_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_loader_if.sv
// cram_loader_if
//   Bitstream word handshake between the host/bitstream source (master) and
//   cram_loader (slave).
//   cfg_word  : bitstream word, bit 0 is the first bit shifted into the chain
//   cfg_valid : source presents a word on cfg_word
//   cfg_ready : loader takes cfg_word at the end of this cycle
interface cram_loader_if #(
  parameter int WORD_W = 16
) ();
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_word, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_word, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/cram_loader.sv
// cram_loader
//   Configuration sequencer for the fabric's serial CRAM chain. It takes
//   bitstream words over a valid/ready handshake, shifts them LSB-first into
//   the chain head and counts exactly CHAIN_BITS shifts. The user fabric is
//   held disabled until a pass completes.
// Ports
//   clk, nrst    : config clock, asynchronous active-low reset
//   start, abort : one-cycle pulses that begin / cancel a pass
//   cfg          : bitstream word handshake (cfg_word, cfg_valid, cfg_ready)
//   cram_en      : chain enable, high while busy
//   config_en    : chain shift enable, high exactly on shift cycles
//   config_data  : serial bit to config_data_in of the first tile
//   le_en        : fabric logic enable, 1 only after a completed pass
//   busy, done   : pass in progress / one-cycle completion pulse
//   err          : sticky abort flag, cleared by start
//   bits_shifted : shifts performed in the current or last pass
module cram_loader #(
  parameter int CHAIN_BITS = 1024,
  parameter int WORD_W     = 16,
  parameter int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  cram_loader_if.slave     cfg,
  output logic             cram_en,
  output logic             config_en,
  output logic             config_data,
  output logic             le_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] bits_shifted
);

  localparam int               WB_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_BITS - 1);
  localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, SETTLE, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg;      // bits of the current word not yet presented
  logic [WB_W-1:0]   word_bit;  // index of the bit presented on config_data
  logic              accept;
  logic              shift;
  logic              do_start;
  logic              do_abort;

  // Next-state logic. A SHIFT cycle always counts its bit, even when abort
  // arrives in that cycle, because config_en is already high for it; this
  // keeps bits_shifted equal to the number of config_en cycles. The chain
  // end check takes priority over the word end, so a partial last word
  // never triggers another fetch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift    = 1'b0;
    do_start = 1'b0;
    do_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          do_start = 1'b1;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d  = IDLE;
          do_abort = 1'b1;
        end else if (cfg.cfg_valid && cfg.cfg_ready) begin
          state_d = SHIFT;
          accept  = 1'b1;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (abort) begin
          state_d  = IDLE;
          do_abort = 1'b1;
        end else if (bits_shifted == LAST_BIT) begin
          state_d = SETTLE;
        end else if (word_bit == LAST_WB) begin
          state_d = FETCH;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d  = IDLE;
          do_abort = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs. Outputs are derived from the
  // state being entered so they line up with that state's cycle; the first
  // bit of a word goes straight to config_data on the accept edge and sreg
  // keeps the rest.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      sreg          <= '0;
      word_bit      <= '0;
      cfg.cfg_ready <= 1'b0;
      cram_en       <= 1'b0;
      config_en     <= 1'b0;
      config_data   <= 1'b0;
      le_en         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      bits_shifted  <= '0;
    end else begin
      state_q       <= state_d;
      cfg.cfg_ready <= (state_d == FETCH);
      busy          <= (state_d == FETCH) || (state_d == SHIFT) || (state_d == SETTLE);
      cram_en       <= (state_d == FETCH) || (state_d == SHIFT) || (state_d == SETTLE);
      config_en     <= (state_d == SHIFT);
      done          <= (state_d == DONE);

      if (accept) begin
        config_data <= cfg.cfg_word[0];
        sreg        <= cfg.cfg_word >> 1;
        word_bit    <= '0;
      end else if (shift && (state_d == SHIFT)) begin
        config_data <= sreg[0];
        sreg        <= sreg >> 1;
        word_bit    <= word_bit + WB_W'(1);
      end else begin
        config_data <= 1'b0;
      end

      if (shift) begin
        bits_shifted <= bits_shifted + CNT_W'(1);
      end

      if (do_start) begin
        bits_shifted <= '0;
        err          <= 1'b0;
        le_en        <= 1'b0;
      end
      if (do_abort) begin
        err <= 1'b1;
      end
      if (state_d == DONE) begin
        le_en <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cram_loader.sv
// tb_cram_loader
//   Self-checking bench for cram_loader. Two instances: a 20-bit chain with
//   8-bit words and a 16-bit chain with one 16-bit word. Issuing a pass pushes
//   the expected serial stream and completion record into queues; monitors
//   pop and compare whenever the DUT shifts a bit or pulses done.
module tb_cram_loader;

  localparam int A_BITS  = 20;
  localparam int A_W     = 8;
  localparam int A_CNT   = $clog2(A_BITS + 1);
  localparam int A_WORDS = (A_BITS + A_W - 1) / A_W;
  localparam int B_BITS  = 16;
  localparam int B_W     = 16;
  localparam int B_CNT   = $clog2(B_BITS + 1);

  typedef struct {
    int start_edge;
    int lat;
    int words;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic             start_a, abort_a;
  logic             cram_en_a, config_en_a, config_data_a, le_en_a, busy_a, done_a, err_a;
  logic [A_CNT-1:0] bits_shifted_a;
  cram_loader_if #(.WORD_W(A_W)) cfg_a ();

  // Instance B signals
  logic             start_b, abort_b;
  logic             cram_en_b, config_en_b, config_data_b, le_en_b, busy_b, done_b, err_b;
  logic [B_CNT-1:0] bits_shifted_b;
  cram_loader_if #(.WORD_W(B_W)) cfg_b ();

  cram_loader #(.CHAIN_BITS(A_BITS), .WORD_W(A_W)) dut_a (
    .clk(clk), .nrst(nrst), .start(start_a), .abort(abort_a), .cfg(cfg_a),
    .cram_en(cram_en_a), .config_en(config_en_a), .config_data(config_data_a),
    .le_en(le_en_a), .busy(busy_a), .done(done_a), .err(err_a),
    .bits_shifted(bits_shifted_a)
  );

  cram_loader #(.CHAIN_BITS(B_BITS), .WORD_W(B_W)) dut_b (
    .clk(clk), .nrst(nrst), .start(start_b), .abort(abort_b), .cfg(cfg_b),
    .cram_en(cram_en_b), .config_en(config_en_b), .config_data(config_data_b),
    .le_en(le_en_b), .busy(busy_b), .done(done_b), .err(err_b),
    .bits_shifted(bits_shifted_b)
  );

  // Scoreboard state
  logic [A_W-1:0] src_words[$];
  int             src_gaps[$];
  bit             exp_bits[$];
  exp_t           exp_q[$];
  bit             hs_armed;
  int             hs_count;
  int             pass_shifts;
  bit             exp_bits_b[$];
  int             exp_done_b = 0;
  int             hs_b = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flagFail(input string name, input string what);
    checks++;
    failures++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Word source for instance A. Gap cycles only elapse while the loader is
  // asking for a word, so a gap of N delays completion by exactly N cycles.
  initial begin : source_a
    cfg_a.cfg_valid = 1'b0;
    cfg_a.cfg_word  = '0;
    hs_armed        = 1'b0;
    hs_count        = 0;
    forever begin
      @(negedge clk);
      if (hs_armed) begin
        if (src_words.size() > 0) begin
          void'(src_words.pop_front());
          void'(src_gaps.pop_front());
        end
        hs_count++;
      end
      if (src_words.size() == 0) begin
        cfg_a.cfg_valid = 1'b0;
        cfg_a.cfg_word  = A_W'($urandom);
      end else if (cfg_a.cfg_ready && src_gaps[0] > 0) begin
        cfg_a.cfg_valid = 1'b0;
        cfg_a.cfg_word  = A_W'($urandom);
        src_gaps[0]     = src_gaps[0] - 1;
      end else begin
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_word  = src_words[0];
      end
      hs_armed = cfg_a.cfg_valid && cfg_a.cfg_ready;
    end
  end

  // Monitor for instance A
  initial begin : monitor_a
    bit   b;
    exp_t e;
    pass_shifts = 0;
    forever begin
      @(negedge clk);
      if (config_en_a) begin
        pass_shifts++;
        checkOutput("a_shift_enables", 32'({cram_en_a, busy_a, cfg_a.cfg_ready}), 32'(3'b110));
        if (exp_bits.size() == 0) flagFail("a_extra_shift", "config_en with no bit expected");
        else begin
          b = exp_bits.pop_front();
          checkOutput("a_config_data", 32'(config_data_a), 32'(b));
        end
      end
      if (done_a) begin
        if (exp_q.size() == 0) flagFail("a_unexpected_done", "done with no pass pending");
        else begin
          e = exp_q.pop_front();
          checkOutput("a_done_latency", 32'(cyc - e.start_edge + 1), 32'(e.lat));
          checkOutput("a_done_bits", 32'(bits_shifted_a), 32'(A_BITS));
          checkOutput("a_done_handshakes", 32'(hs_count), 32'(e.words));
          checkOutput("a_done_stream_left", 32'(exp_bits.size()), 32'(0));
          checkOutput("a_done_flags", 32'({le_en_a, busy_a, err_a}), 32'(3'b100));
        end
      end
    end
  end

  // Monitor for instance B
  initial begin : monitor_b
    bit b;
    forever begin
      @(negedge clk);
      if (cfg_b.cfg_valid && cfg_b.cfg_ready) hs_b++;
      if (config_en_b) begin
        if (exp_bits_b.size() == 0) flagFail("b_extra_shift", "config_en with no bit expected");
        else begin
          b = exp_bits_b.pop_front();
          checkOutput("b_config_data", 32'(config_data_b), 32'(b));
        end
      end
      if (done_b) begin
        if (exp_done_b == 0) flagFail("b_unexpected_done", "done with no pass pending");
        else begin
          exp_done_b--;
          checkOutput("b_done_bits", 32'(bits_shifted_b), 32'(B_BITS));
          checkOutput("b_done_handshakes", 32'(hs_b), 32'(1));
          checkOutput("b_done_stream_left", 32'(exp_bits_b.size()), 32'(0));
          checkOutput("b_done_le_en", 32'(le_en_b), 32'(1));
        end
      end
    end
  end

  // Issue one pass on instance A: the reference stream is bit i%A_W of word
  // i/A_W for every chain bit, and completion costs one accept cycle per
  // word, one cycle per chain bit, settle, done and any source gaps.
  task automatic applyStimulus(input logic [A_W-1:0] w0, input logic [A_W-1:0] w1,
                               input logic [A_W-1:0] w2, input int g0, input int g1,
                               input int g2, input bit with_abort);
    logic [A_W-1:0] w [A_WORDS];
    exp_t           e;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    for (int i = 0; i < A_BITS; i++) exp_bits.push_back(w[i / A_W][i % A_W]);
    for (int k = 0; k < A_WORDS; k++) src_words.push_back(w[k]);
    src_gaps.push_back(g0);
    src_gaps.push_back(g1);
    src_gaps.push_back(g2);
    hs_count    = 0;
    pass_shifts = 0;
    @(negedge clk);
    start_a      = 1'b1;
    abort_a      = with_abort;
    e.start_edge = cyc + 1;
    e.lat        = A_WORDS + A_BITS + 2 + g0 + g1 + g2;
    e.words      = A_WORDS;
    exp_q.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      flagFail("a_done_timeout", "no done within 300 cycles");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Returns at the negedge of the shift cycle in which bits_shifted shows n.
  task automatic waitShift(input int n);
    bit ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (config_en_a && int'(bits_shifted_a) == n) ok = 1'b1;
    end
    if (!ok) flagFail("a_shift_timeout", "shift count never reached");
  endtask

  task automatic flushA();
    exp_bits.delete();
    src_words.delete();
    src_gaps.delete();
    exp_q.delete();
  endtask

  task automatic abortAt(input int n);
    applyStimulus(A_W'($urandom), A_W'($urandom), A_W'($urandom), 0, 0, 0, 1'b0);
    waitShift(n - 1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checkOutput("abort_flags", 32'({busy_a, err_a, le_en_a, cfg_a.cfg_ready, config_en_a}),
                32'(5'b01000));
    checkOutput("abort_count", 32'(bits_shifted_a), 32'(n));
    checkOutput("abort_shifts", 32'(pass_shifts), 32'(n));
    flushA();
    repeat (6) @(negedge clk);
    checkOutput("abort_frozen", 32'({bits_shifted_a, err_a}), 32'({A_CNT'(n), 1'b1}));
  endtask

  task automatic applyB(input logic [B_W-1:0] w);
    int n = 0;
    for (int i = 0; i < B_BITS; i++) exp_bits_b.push_back(w[i % B_W]);
    hs_b = 0;
    exp_done_b++;
    @(negedge clk);
    cfg_b.cfg_word  = w;
    cfg_b.cfg_valid = 1'b1;
    start_b         = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (exp_done_b != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_done_b != 0) begin
      flagFail("b_done_timeout", "no done within 300 cycles");
      exp_done_b = 0;
    end
    cfg_b.cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    nrst            = 1'b0;
    start_a         = 1'b0;
    abort_a         = 1'b0;
    start_b         = 1'b0;
    abort_b         = 1'b0;
    cfg_b.cfg_valid = 1'b0;
    cfg_b.cfg_word  = '0;
    @(negedge clk);
    #1;
    checkOutput("a_reset_outputs", 32'({cfg_a.cfg_ready, cram_en_a, config_en_a, config_data_a,
                le_en_a, busy_a, done_a, err_a}), 32'(0));
    checkOutput("a_reset_count", 32'(bits_shifted_a), 32'(0));
    checkOutput("b_reset_outputs", 32'({cfg_b.cfg_ready, cram_en_b, config_en_b, config_data_b,
                le_en_b, busy_b, done_b, err_b, bits_shifted_b}), 32'(0));
    @(negedge clk);
    nrst = 1'b1;

    $display("[TB] basic pass A5 3C FF");
    applyStimulus(8'hA5, 8'h3C, 8'hFF, 0, 0, 0, 1'b0);
    checkOutput("busy_after_start", 32'({busy_a, le_en_a}), 32'(2'b10));
    waitDone();
    checkOutput("le_en_after_done", 32'({le_en_a, busy_a}), 32'(2'b10));
    checkOutput("bits_after_done", 32'(bits_shifted_a), 32'(A_BITS));

    $display("[TB] five-cycle source gap before the third word");
    applyStimulus(8'hA5, 8'h3C, 8'hFF, 0, 0, 5, 1'b0);
    waitDone();

    $display("[TB] abort in IDLE is ignored");
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    @(negedge clk);
    checkOutput("idle_abort", 32'({err_a, busy_a, le_en_a}), 32'(3'b001));

    $display("[TB] abort after 10 bits");
    abortAt(10);
    applyStimulus(A_W'($urandom), A_W'($urandom), A_W'($urandom), 0, 1, 0, 1'b0);
    checkOutput("start_clears_err", 32'({err_a, bits_shifted_a}), 32'(0));
    waitDone();

    $display("[TB] start pulsed during SHIFT");
    applyStimulus(8'hA5, 8'h3C, 8'hFF, 0, 0, 0, 1'b0);
    waitShift(5);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    waitDone();

    $display("[TB] start and abort together in IDLE");
    applyStimulus(A_W'($urandom), A_W'($urandom), A_W'($urandom), 0, 0, 0, 1'b1);
    checkOutput("start_wins", 32'({busy_a, err_a}), 32'(2'b10));
    waitDone();

    $display("[TB] reset mid-SHIFT");
    applyStimulus(A_W'($urandom), A_W'($urandom), A_W'($urandom), 0, 0, 0, 1'b0);
    waitShift(7);
    nrst = 1'b0;
    #1;
    checkOutput("midshift_reset_outputs", 32'({cfg_a.cfg_ready, cram_en_a, config_en_a,
                config_data_a, le_en_a, busy_a, done_a, err_a}), 32'(0));
    checkOutput("midshift_reset_count", 32'(bits_shifted_a), 32'(0));
    flushA();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    applyStimulus(A_W'($urandom), A_W'($urandom), A_W'($urandom), 0, 0, 0, 1'b0);
    waitDone();

    $display("[TB] randomized passes");
    for (int p = 0; p < 5; p++) begin
      applyStimulus(A_W'($urandom), A_W'($urandom), A_W'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'b0);
      waitDone();
      checkOutput("random_le_en_hold", 32'(le_en_a), 32'(1));
    end
    abortAt(int'($urandom_range(1, A_BITS - 1)));

    $display("[TB] single full-width word 0x8001");
    applyB(16'h8001);
    checkOutput("b_idle_after_done", 32'({busy_b, cfg_b.cfg_ready, le_en_b}), 32'(3'b001));
    for (int p = 0; p < 2; p++) applyB(B_W'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
